// File: rtl/sync_frame_deserializer.sv
// Collects the serial payload that follows a sync detect and presents it as a
// parallel word on a valid/ready output. `define FRAME_PARITY_EN adds a trailing even-parity bit.
module sync_frame_deserializer #(
    parameter int PAYLOAD_W = 8,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    input  logic                 detect,
    input  logic                 ready,
    output logic [PAYLOAD_W-1:0] data,
    output logic                 valid,
    output logic                 overrun,
    output logic                 busy,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic                 parity_err
);

`ifdef FRAME_PARITY_EN
    localparam int FRAME_LEN = PAYLOAD_W + 1;
`else
    localparam int FRAME_LEN = PAYLOAD_W;
`endif
    // The shift register holds every frame bit except the one sampled on the final edge.
    localparam int SHIFT_W   = FRAME_LEN - 1;
    localparam int BIT_CNT_W = $clog2(FRAME_LEN);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        HUNT  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic [BIT_CNT_W-1:0]   w_next_bit_cnt;
    logic [SHIFT_W-1:0]     r_shift;
    logic [SHIFT_W-1:0]     w_next_shift;
    logic [PAYLOAD_W-1:0]   w_payload;
    logic                   w_complete;
    logic                   w_load;
    logic                   w_drop;

    logic [PAYLOAD_W-1:0]   r_data;
    logic                   r_valid;
    logic                   r_overrun;
    logic                   r_busy;
    logic [CNT_W-1:0]       r_frame_cnt;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_next_state   = r_state;
        w_next_bit_cnt = r_bit_cnt;
        w_next_shift   = r_shift;
        w_complete     = 1'b0;
        case (r_state)
            HUNT: begin
                if (detect) begin
                    w_next_shift   = SHIFT_W'(din);
                    w_next_bit_cnt = BIT_CNT_W'(1);
                    w_next_state   = SHIFT;
                end
            end
            SHIFT: begin
                w_next_shift = SHIFT_W'({r_shift, din});
                if (r_bit_cnt == LAST_BIT) begin
                    w_complete     = 1'b1;
                    w_next_bit_cnt = '0;
                    w_next_state   = HUNT;
                end else begin
                    w_next_bit_cnt = r_bit_cnt + BIT_CNT_W'(1);
                end
            end
            default: w_next_state = HUNT;
        endcase
    end

    assign w_load = w_complete && (!r_valid || ready);
    assign w_drop = w_complete && r_valid && !ready;

`ifdef FRAME_PARITY_EN
    logic r_parity_err;
    logic w_parity_err;
    assign w_payload    = r_shift;
    assign w_parity_err = ^{r_shift, din};
    assign parity_err   = r_parity_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_parity_err <= 1'b0;
        else if (w_load) r_parity_err <= w_parity_err;
    end
`else
    assign w_payload  = {r_shift, din};
    assign parity_err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= HUNT;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_next_state;
            r_bit_cnt <= w_next_bit_cnt;
            r_shift   <= w_next_shift;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_overrun <= w_drop;
            r_busy    <= (w_next_state == SHIFT);
            // A load wins over a concurrent handshake, so valid never dips between words.
            if (w_load) begin
                r_data      <= w_payload;
                r_valid     <= 1'b1;
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end else if (ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign overrun   = r_overrun;
    assign busy      = r_busy;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_sync_frame_deserializer.sv
// Self-checking bench for sync_frame_deserializer: directed scenarios plus random
// streams, compared every cycle against a frame-schedule reference model.
module tb_sync_frame_deserializer;

    localparam int W  = 8;
    localparam int CW = 8;
`ifdef FRAME_PARITY_EN
    localparam int FL  = W + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int FL  = W;
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          din = 1'b0;
    logic          detect = 1'b0;
    logic          ready = 1'b0;
    logic [W-1:0]  data;
    logic          valid;
    logic          overrun;
    logic          busy;
    logic [CW-1:0] frame_cnt;
    logic          parity_err;

    sync_frame_deserializer #(.PAYLOAD_W(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .detect     (detect),
        .ready      (ready),
        .data       (data),
        .valid      (valid),
        .overrun    (overrun),
        .busy       (busy),
        .frame_cnt  (frame_cnt),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    bit q_din[$];
    bit q_det[$];
    bit q_rdy[$];

    logic [W-1:0]  m_data  = '0;
    logic          m_valid = 1'b0;
    logic          m_ovr   = 1'b0;
    logic          m_busy  = 1'b0;
    logic [CW-1:0] m_cnt   = '0;
    logic          m_perr  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check($sformatf("%s.data", tag),       32'(data),       32'(m_data));
        check($sformatf("%s.valid", tag),      32'(valid),      32'(m_valid));
        check($sformatf("%s.overrun", tag),    32'(overrun),    32'(m_ovr));
        check($sformatf("%s.busy", tag),       32'(busy),       32'(m_busy));
        check($sformatf("%s.frame_cnt", tag),  32'(frame_cnt),  32'(m_cnt));
        check($sformatf("%s.parity_err", tag), 32'(parity_err), 32'(m_perr));
    endtask

    // Append nb bits of v, MSB first; detect marks the first bit when det_first is set.
    task automatic push(input logic [15:0] v, input int nb, input bit det_first, input bit rdy);
        for (int i = nb - 1; i >= 0; i--) begin
            q_din.push_back(v[i]);
            q_det.push_back(det_first && (i == nb - 1));
            q_rdy.push_back(rdy);
        end
    endtask

    // Sync pattern 1101, then the payload with detect on its first bit, then the parity bit if enabled.
    task automatic push_frame(input logic [W-1:0] p, input bit rdy, input bit par_bit);
        push(16'hD, 4, 1'b0, rdy);
        push(16'(p), W, 1'b1, rdy);
        if (PAR) push(16'(par_bit), 1, 1'b0, rdy);
    endtask

    // Build the frame schedule for the queued stream, then drive it and compare every cycle.
    task automatic run(input string tag);
        int           n;
        int           t;
        bit           comp[];
        logic [W-1:0] cpay[];
        bit           cpar[];
        bit           bsy[];
        n    = q_din.size();
        comp = new[n];
        cpay = new[n];
        cpar = new[n];
        bsy  = new[n];
        t    = 0;
        while (t < n) begin
            if (q_det[t]) begin
                for (int k = 0; k < FL - 1 && t + k < n; k++) bsy[t + k] = 1'b1;
                if (t + FL - 1 < n) begin
                    logic [W-1:0] p;
                    bit           x;
                    p = '0;
                    x = 1'b0;
                    for (int k = 0; k < W; k++) p = {p[W-2:0], q_din[t + k]};
                    for (int k = 0; k < FL; k++) x = x ^ q_din[t + k];
                    comp[t + FL - 1] = 1'b1;
                    cpay[t + FL - 1] = p;
                    cpar[t + FL - 1] = PAR ? x : 1'b0;
                end
                t += FL;
            end else begin
                t++;
            end
        end
        for (int c = 0; c < n; c++) begin
            din    = q_din[c];
            detect = q_det[c];
            ready  = q_rdy[c];
            @(negedge clk);
            m_busy = bsy[c];
            if (comp[c]) begin
                if (!m_valid || q_rdy[c]) begin
                    m_data  = cpay[c];
                    m_valid = 1'b1;
                    m_cnt   = m_cnt + 1'b1;
                    m_perr  = cpar[c];
                    m_ovr   = 1'b0;
                end else begin
                    m_ovr = 1'b1;
                end
            end else begin
                m_ovr = 1'b0;
                if (q_rdy[c]) m_valid = 1'b0;
            end
            check_all($sformatf("%s[%0d]", tag, c));
        end
        detect = 1'b0;
        ready  = 1'b0;
        q_din.delete();
        q_det.delete();
        q_rdy.delete();
    endtask

    initial begin
        #7;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        push(16'($urandom), 16, 1'b0, 1'b0);
        push(16'($urandom), 4, 1'b0, 1'b1);
        run("idle");

        push_frame(8'hA5, 1'b0, ^8'hA5);
        push(16'h0, 4, 1'b0, 1'b0);
        push(16'h0, 1, 1'b0, 1'b1);
        push(16'h0, 3, 1'b0, 1'b0);
        run("single");

        push_frame(8'h3C, 1'b1, ^8'h3C);
        push_frame(8'hC3, 1'b1, ^8'hC3);
        push(16'h0, 3, 1'b0, 1'b1);
        run("b2b");

        push_frame(8'h11, 1'b0, ^8'h11);
        push_frame(8'h22, 1'b0, ^8'h22);
        push(16'h0, 2, 1'b0, 1'b0);
        push(16'h0, 1, 1'b0, 1'b1);
        push(16'h0, 2, 1'b0, 1'b0);
        run("overrun");

        // Handshake lands exactly on frame 2's completion edge.
        push_frame(8'h5A, 1'b0, ^8'h5A);
        push_frame(8'h96, 1'b0, ^8'h96);
        q_rdy[q_rdy.size() - 1] = 1'b1;
        push(16'h0, 3, 1'b0, 1'b0);
        run("simul");

        // Reset asserted between edges, three bits into a frame, with a word still held.
        push(16'hD, 4, 1'b0, 1'b0);
        push(16'h5, 3, 1'b1, 1'b0);
        run("pre_reset");
        #2 rst = 1'b1;
        #1;
        m_data  = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_busy  = 1'b0;
        m_cnt   = '0;
        m_perr  = 1'b0;
        check_all("async_reset");
        @(negedge clk);
        rst = 1'b0;
        push(16'($urandom), 16, 1'b0, 1'b0);
        push(16'($urandom), 8, 1'b0, 1'b0);
        run("post_reset");

`ifdef FRAME_PARITY_EN
        push_frame(8'hA5, 1'b0, 1'b0);
        push(16'h0, 2, 1'b0, 1'b1);
        push_frame(8'hA4, 1'b0, 1'b0);
        push(16'h0, 2, 1'b0, 1'b0);
        run("parity");
`endif

        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 150; c++) begin
                q_din.push_back(1'($urandom));
                q_det.push_back((c <= 150 - FL) && ($urandom_range(0, 4) == 0));
                q_rdy.push_back($urandom_range(0, 3) < (r % 4));
            end
            run($sformatf("random%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
